// File: rtl/pc_redirect_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : pc_redirect_unit                                                 |
// | Purpose : Fetch PC sequencer with branch/return redirect, timed pipeline   |
// |           flush and a circular return-address stack.                       |
// | Option  : PC_MISALIGN_TRAP_EN - misaligned redirect targets go to TRAP_PC  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pc_redirect_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          RAS_DEPTH    = 4,
  parameter int          FLUSH_CYCLES = 2,
  parameter logic [31:0] TRAP_PC      = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        br_valid,
  input  logic        is_branch,
  input  logic        br_link,
  input  logic [31:0] br_pc,
  input  logic [31:0] br_target,
  input  logic        ret_valid,
  output logic [31:0] pc,
  output logic        flush,
  output logic        busy,
  output logic        ras_ovf,
  output logic        ras_unf
);

  localparam int               PTR_W          = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int               CNT_W          = PTR_W + 1;
  localparam logic [2:0]       C_FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_RAS_FULL     = CNT_W'(RAS_DEPTH);
  localparam logic [CNT_W-1:0] C_CNT_ONE      = CNT_W'(1);
  localparam logic [PTR_W-1:0] C_PTR_ONE      = PTR_W'(1);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       fcnt_q, fcnt_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      ras_q [RAS_DEPTH];
  logic [31:0]      ras_d [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ras_ovf_q, ras_ovf_d;
  logic             ras_unf_q, ras_unf_d;

  logic             w_taken;
  logic             w_ret;
  logic             w_ret_empty;
  logic             w_push;
  logic             w_redirect;
  logic [PTR_W-1:0] w_top_idx;
  logic [31:0]      w_raw_target;
  logic [31:0]      w_target;

  // A return only counts when no branch resolves in the same cycle.
  assign w_taken      = br_valid & is_branch;
  assign w_ret        = ret_valid & ~br_valid & (count_q != '0);
  assign w_ret_empty  = ret_valid & ~br_valid & (count_q == '0);
  assign w_push       = w_taken & br_link;
  assign w_redirect   = w_taken | w_ret;
  assign w_top_idx    = ptr_q - C_PTR_ONE;
  assign w_raw_target = w_taken ? br_target : ras_q[w_top_idx];

`ifdef PC_MISALIGN_TRAP_EN
  assign w_target = (w_raw_target[1:0] != 2'b00) ? TRAP_PC : w_raw_target;
`else
  logic w_unused_trap;
  assign w_unused_trap = ^TRAP_PC;
  assign w_target      = w_raw_target;
`endif

  always_comb begin
    pc_d      = pc_q;
    ptr_d     = ptr_q;
    count_d   = count_q;
    ras_ovf_d = ras_ovf_q;
    ras_unf_d = ras_unf_q | w_ret_empty;
    state_d   = state_q;
    fcnt_d    = fcnt_q;
    for (int i = 0; i < RAS_DEPTH; i++) begin
      ras_d[i] = ras_q[i];
    end

    if (w_redirect) begin
      pc_d = w_target;
    end else if (!stall) begin
      pc_d = pc_q + 32'd4;
    end

    // Writing at the pointer when full naturally replaces the oldest entry.
    if (w_push) begin
      ras_d[ptr_q] = br_pc + 32'd4;
      ptr_d        = ptr_q + C_PTR_ONE;
      if (count_q == C_RAS_FULL) begin
        ras_ovf_d = 1'b1;
      end else begin
        count_d = count_q + C_CNT_ONE;
      end
    end else if (w_ret) begin
      ptr_d   = w_top_idx;
      count_d = count_q - C_CNT_ONE;
    end

    case (state_q)
      ST_RUN: begin
        if (w_redirect) begin
          state_d = ST_FLUSH;
          fcnt_d  = C_FLUSH_RELOAD;
        end
      end
      ST_FLUSH: begin
        if (w_redirect) begin
          fcnt_d = C_FLUSH_RELOAD;
        end else if (fcnt_q == 3'd0) begin
          state_d = ST_RUN;
        end else begin
          fcnt_d = fcnt_q - 3'd1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      fcnt_q    <= 3'd0;
      pc_q      <= RESET_PC;
      ptr_q     <= '0;
      count_q   <= '0;
      ras_ovf_q <= 1'b0;
      ras_unf_q <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_q[i] <= 32'h0;
      end
    end else begin
      state_q   <= state_d;
      fcnt_q    <= fcnt_d;
      pc_q      <= pc_d;
      ptr_q     <= ptr_d;
      count_q   <= count_d;
      ras_ovf_q <= ras_ovf_d;
      ras_unf_q <= ras_unf_d;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_q[i] <= ras_d[i];
      end
    end
  end

  assign pc      = pc_q;
  assign flush   = (state_q == ST_FLUSH);
  assign busy    = (state_q == ST_FLUSH);
  assign ras_ovf = ras_ovf_q;
  assign ras_unf = ras_unf_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_redirect_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_pc_redirect_unit                                              |
// | Purpose : Directed and randomized checks of pc_redirect_unit against a     |
// |           queue-based reference model.                                     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_pc_redirect_unit;

  localparam logic [31:0] RESET_PC     = 32'h0000_0000;
  localparam int          RAS_DEPTH    = 4;
  localparam int          FLUSH_CYCLES = 2;
  localparam logic [31:0] TRAP_PC      = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0, br_valid = 1'b0, is_branch = 1'b0, br_link = 1'b0;
  logic [31:0] br_pc = '0, br_target = '0;
  logic        ret_valid = 1'b0;
  logic [31:0] pc;
  logic        flush, busy, ras_ovf, ras_unf;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  int          m_fl;
  logic        m_ovf, m_unf;

  pc_redirect_unit #(
    .RESET_PC(RESET_PC), .RAS_DEPTH(RAS_DEPTH),
    .FLUSH_CYCLES(FLUSH_CYCLES), .TRAP_PC(TRAP_PC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .br_valid(br_valid),
    .is_branch(is_branch), .br_link(br_link), .br_pc(br_pc),
    .br_target(br_target), .ret_valid(ret_valid), .pc(pc), .flush(flush),
    .busy(busy), .ras_ovf(ras_ovf), .ras_unf(ras_unf)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] tgt_fix(input logic [31:0] t);
`ifdef PC_MISALIGN_TRAP_EN
    return (t[1:0] != 2'b00) ? TRAP_PC : t;
`else
    return t;
`endif
  endfunction

  task automatic model_reset();
    m_pc  = RESET_PC;
    m_ras.delete();
    m_fl  = 0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model on the edge, sample 1ns later.
  task automatic cycle(input logic bv, input logic ib, input logic bl,
                       input logic [31:0] bpc, input logic [31:0] btgt,
                       input logic rv, input logic st);
    bit tk, rt;
    br_valid = bv; is_branch = ib; br_link = bl; br_pc = bpc;
    br_target = btgt; ret_valid = rv; stall = st;
    @(posedge clk);
    tk = bv && ib;
    rt = rv && !bv && (m_ras.size() > 0);
    if (rv && !bv && m_ras.size() == 0) m_unf = 1'b1;
    if (tk || rt) m_fl = FLUSH_CYCLES;
    else if (m_fl > 0) m_fl--;
    if (tk) begin
      m_pc = tgt_fix(btgt);
      if (bl) begin
        if (m_ras.size() == RAS_DEPTH) begin
          void'(m_ras.pop_front());
          m_ovf = 1'b1;
        end
        m_ras.push_back(bpc + 32'd4);
      end
    end else if (rt) begin
      m_pc = tgt_fix(m_ras.pop_back());
    end else if (!st) begin
      m_pc = m_pc + 32'd4;
    end
    #1;
  endtask

  task automatic idle(input logic st);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, st);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    model_reset();
    checks++; if (pc !== RESET_PC) begin errors++; $display("FAIL reset_pc got %h want %h", pc, RESET_PC); end
    checks++; if (flush !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_flush got %b/%b want 0/0", flush, busy); end
    checks++; if (ras_ovf !== 1'b0 || ras_unf !== 1'b0) begin errors++; $display("FAIL reset_flags got %b/%b want 0/0", ras_ovf, ras_unf); end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle(1'b0);
      checks++; if (pc !== m_pc || flush !== 1'b0) begin errors++; $display("FAIL free_run pc %h flush %b want %h 0", pc, flush, m_pc); end
    end
  endtask

  task automatic test_branch();
    cycle(1'b1, 1'b1, 1'b0, pc, 32'h40, 1'b0, 1'b0);
    checks++; if (pc !== 32'h40 || flush !== 1'b1) begin errors++; $display("FAIL branch_redirect pc %h flush %b want 00000040 1", pc, flush); end
    for (int i = 0; i < 3; i++) begin
      idle(1'b0);
      checks++; if (pc !== m_pc || flush !== (m_fl > 0) || busy !== (m_fl > 0)) begin
        errors++; $display("FAIL branch_after pc %h flush %b want %h %b", pc, flush, m_pc, m_fl > 0); end
    end
  endtask

  task automatic test_call_return();
    cycle(1'b1, 1'b1, 1'b1, 32'h20, 32'h80, 1'b0, 1'b0);
    checks++; if (pc !== 32'h80 || flush !== 1'b1) begin errors++; $display("FAIL call_pc pc %h flush %b want 00000080 1", pc, flush); end
    repeat (3) idle(1'b0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checks++; if (pc !== 32'h24 || flush !== 1'b1) begin errors++; $display("FAIL return_pc pc %h flush %b want 00000024 1", pc, flush); end
    repeat (2) idle(1'b0);
    checks++; if (pc !== m_pc || flush !== 1'b0) begin errors++; $display("FAIL return_after pc %h flush %b want %h 0", pc, flush, m_pc); end
  endtask

  task automatic test_ras_overflow();
    logic [31:0] exp_ret [4];
    exp_ret[0] = 32'h44; exp_ret[1] = 32'h34; exp_ret[2] = 32'h24; exp_ret[3] = 32'h14;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1, 1'b1, 32'(i * 16), 32'h1000 + 32'(i * 64), 1'b0, 1'b0);
    end
    checks++; if (ras_ovf !== 1'b1 || ras_unf !== 1'b0) begin errors++; $display("FAIL ras_ovf got %b/%b want 1/0", ras_ovf, ras_unf); end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      checks++; if (pc !== exp_ret[i]) begin errors++; $display("FAIL ras_pop%0d got %h want %h", i, pc, exp_ret[i]); end
    end
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checks++; if (pc !== 32'h18 || ras_unf !== 1'b1) begin errors++; $display("FAIL ras_unf pc %h unf %b want 00000018 1", pc, ras_unf); end
    checks++; if (flush !== (m_fl > 0)) begin errors++; $display("FAIL ras_unf_flush got %b want %b", flush, m_fl > 0); end
    repeat (3) idle(1'b0);
  endtask

  task automatic test_stall_redirect();
    cycle(1'b1, 1'b1, 1'b0, pc, 32'h200, 1'b0, 1'b1);
    checks++; if (pc !== 32'h200 || flush !== 1'b1) begin errors++; $display("FAIL stall_redirect pc %h flush %b want 00000200 1", pc, flush); end
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      checks++; if (pc !== 32'h200 || flush !== (m_fl > 0)) begin errors++; $display("FAIL stall_hold pc %h flush %b want 00000200 %b", pc, flush, m_fl > 0); end
    end
    idle(1'b0);
  endtask

  task automatic test_back_to_back();
    cycle(1'b1, 1'b1, 1'b0, pc, 32'h300, 1'b0, 1'b0);
    idle(1'b0);
    // Redirect while flushing, with a colliding return that must be ignored.
    cycle(1'b1, 1'b1, 1'b1, 32'h304, 32'h400, 1'b1, 1'b0);
    checks++; if (pc !== 32'h400 || flush !== 1'b1) begin errors++; $display("FAIL b2b_redirect pc %h flush %b want 00000400 1", pc, flush); end
    // Not-taken branch with link set: no redirect and no push.
    cycle(1'b1, 1'b0, 1'b1, 32'h500, 32'h600, 1'b0, 1'b0);
    checks++; if (pc !== 32'h404 || flush !== 1'b1) begin errors++; $display("FAIL b2b_reload pc %h flush %b want 00000404 1", pc, flush); end
    idle(1'b0);
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL b2b_end flush %b want 0", flush); end
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checks++; if (pc !== 32'h308) begin errors++; $display("FAIL b2b_ret got %h want 00000308", pc); end
  endtask

  task automatic test_random();
    logic bv, ib, bl, rv, st;
    logic [31:0] bpc, btgt;
    for (int i = 0; i < 400; i++) begin
      bv   = ($urandom_range(0, 3) == 0);
      ib   = $urandom_range(0, 1) == 1;
      bl   = $urandom_range(0, 1) == 1;
      rv   = ($urandom_range(0, 3) == 0);
      st   = ($urandom_range(0, 2) == 0);
      bpc  = $urandom & 32'hFFFF_FFFC;
      btgt = $urandom;
      if ($urandom_range(0, 7) != 0) btgt[1:0] = 2'b00;
      cycle(bv, ib, bl, bpc, btgt, rv, st);
      checks++; if (pc !== m_pc || flush !== (m_fl > 0) || busy !== (m_fl > 0) || ras_ovf !== m_ovf || ras_unf !== m_unf) begin
        errors++;
        $display("FAIL random%0d pc %h fl %b bz %b ovf %b unf %b want %h %b %b %b", i, pc, flush, busy, ras_ovf, ras_unf, m_pc, m_fl > 0, m_ovf, m_unf);
      end
    end
  endtask

  task automatic test_async_reset();
    cycle(1'b1, 1'b1, 1'b1, 32'h700, 32'h800, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++; if (pc !== RESET_PC || flush !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL async_reset pc %h flush %b busy %b want %h 0 0", pc, flush, busy, RESET_PC); end
    checks++; if (ras_ovf !== 1'b0 || ras_unf !== 1'b0) begin errors++; $display("FAIL async_reset_flags got %b/%b want 0/0", ras_ovf, ras_unf); end
    #2 rst_n = 1'b1;
    idle(1'b0);
    checks++; if (pc !== m_pc || flush !== 1'b0) begin errors++; $display("FAIL post_reset pc %h flush %b want %h 0", pc, flush, m_pc); end
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checks++; if (pc !== m_pc || ras_unf !== 1'b1) begin errors++; $display("FAIL post_reset_ras pc %h unf %b want %h 1", pc, ras_unf, m_pc); end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_call_return();
    test_ras_overflow();
    test_stall_redirect();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
- Program-counter sequencer that consumes the taken/not-taken decision from the branch comparator in EX and steers fetch.
- Holds PC, applies redirects, generates a multi-cycle pipeline flush, and keeps a small return-address stack (RAS) for call/return.
- Sits between the EX-stage branch resolution logic and the instruction-fetch stage.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- RAS_DEPTH, 4, number of return-address stack entries (power of two, 2..16).
- FLUSH_CYCLES, 2, number of cycles flush stays asserted after a redirect (1..7).
- TRAP_PC, 32'h0000_0100, redirect target for a misaligned target (optional feature only).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  fetch hold; PC does not advance sequentially while high.
- br_valid  in  1  a branch/call instruction resolved in EX this cycle.
- is_branch  in  1  taken decision from the comparator; sampled only when br_valid=1.
- br_link  in  1  resolved branch is a call; push br_pc+4 if taken.
- br_pc  in  32  PC of the resolving branch.
- br_target  in  32  taken target address.
- ret_valid  in  1  return instruction resolved in EX; pop RAS.
- pc  out  32  current fetch PC.
- flush  out  1  squash IF/ID contents.
- busy  out  1  high in FLUSH state.
- ras_ovf  out  1  sticky: push while full.
- ras_unf  out  1  sticky: pop while empty.

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC; flush=0; busy=0; ras_ovf=0; ras_unf=0; RAS count=0; state=RUN.
- Redirect condition R = (br_valid & is_branch) | (ret_valid & !br_valid & count!=0).
- Precedence per cycle: taken branch > return > stall > sequential.
  - Taken branch: pc<=br_target.
  - Return: pc<=RAS top; count decrements.
  - Stall: pc holds.
  - Otherwise: pc<=pc+4, wrapping modulo 2^32.
- Redirects are applied even when stall=1.
- br_valid & !is_branch: no redirect; br_link is ignored.
- Taken with br_link=1: push br_pc+4 in the same edge as the redirect.
  - If full: overwrite the oldest entry (circular), count stays RAS_DEPTH, set ras_ovf.
- ret_valid with count=0: no redirect, pc follows sequential/stall rule, set ras_unf.
- br_valid and ret_valid together: ret is ignored with no pop and no flag.
- Sticky flags clear only on reset.
- FSM states:
  - RUN: on R, go to FLUSH with counter=FLUSH_CYCLES-1.
  - FLUSH: flush=1 and busy=1; counter decrements each cycle; go to RUN after the cycle where counter=0.
  - A new R in FLUSH reloads the counter to FLUSH_CYCLES-1 and applies the new redirect.
- Latency: pc updates on the edge that samples R; flush rises on the same edge; both are registered outputs.
- Stall has no effect on the flush counter.

Optional Feature:
- Macro: PC_MISALIGN_TRAP_EN.
- Defined: a taken branch or return whose target[1:0]!=0 redirects to TRAP_PC instead of the target. It still flushes and still pushes if br_link=1.
- Not defined: targets are used as-is, with no alignment check; TRAP_PC is unused.

Test Plan:
- Reset then 3 free-running cycles, RESET_PC=0 -> pc 0,4,8,C; flush=0.
- br_valid=1, is_branch=1, br_target=32'h40 at pc=C -> next pc=40; flush high exactly 2 cycles; then pc 44,48.
- Call: br_pc=20, br_target=80, br_link=1; later ret_valid=1 -> pc=80, then pc=24 after the return; flush after each.
- Five calls with RAS_DEPTH=4 (br_pc=0,10,20,30,40) -> ras_ovf=1; four returns yield 44,34,24,14; fifth return leaves pc sequential and sets ras_unf=1.
- stall=1 with a taken branch to 0x200 -> pc=200 despite stall; while stall remains, pc holds at 200.
- Redirect during FLUSH plus async reset mid-flush -> counter reloads; rst_n low forces pc=RESET_PC and flush=0 immediately, without waiting for a clock.
